// File: rtl/regfile_pkg.sv
// Shared register-file writeback types and constants used by every writeback
// producer and by the write-port arbiter.
package regfile_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Successor of idx in a ring of n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans requesters starting at ptr and
// grants the first one set; the owner holds and advances ptr.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt   = '0;
        found = 1'b0;
        idx   = 32'(ptr);
        for (int unsigned k = 0; k < N; k++) begin
            if (en && !found && req[PW'(idx)]) begin
                gnt[PW'(idx)] = 1'b1;
                found         = 1'b1;
            end
            idx = rr_next(idx, N);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback requesters with
// round-robin valid/ready arbitration, a registered write stage and forwarding hits.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned XLEN    = regfile_pkg::XLEN,
    parameter int unsigned REG_AW  = regfile_pkg::REG_AW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_in,
    input  logic [NUM_REQ*REG_AW-1:0] req_reg_in,
    input  logic [NUM_REQ*XLEN-1:0]   req_data_in,
    output logic [NUM_REQ-1:0]        req_ready_out,
    input  logic                      stall_in,
    output logic                      write_en,
    output logic [REG_AW-1:0]         write_reg,
    output logic [XLEN-1:0]           write_data,
    input  logic [REG_AW-1:0]         reg_num_1_in,
    input  logic [REG_AW-1:0]         reg_num_2_in,
    output logic                      fwd_hit_1_out,
    output logic                      fwd_hit_2_out
);
    import regfile_pkg::*;

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr;
    logic [NUM_REQ-1:0] gnt;
    logic               arb_en;
    logic               accept;
    logic [PW-1:0]      win;
    logic [REG_AW-1:0]  sel_reg;
    logic [XLEN-1:0]    sel_data;

    assign arb_en = rst_n & ~stall_in;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req (req_valid_in),
        .ptr (ptr),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign req_ready_out = gnt;
    assign accept        = |(gnt & req_valid_in);

    // Grant is one-hot, so OR-reducing the gated slices acts as the payload mux.
    always_comb begin
        win      = '0;
        sel_reg  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win      = win | PW'(i);
                sel_reg  = sel_reg | req_reg_in[i*REG_AW +: REG_AW];
                sel_data = sel_data | req_data_in[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes still consume the grant and advance ptr; only write_en is suppressed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= '0;
            write_en   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (accept) begin
            ptr        <= PW'(rr_next(32'(win), NUM_REQ));
            write_en   <= (sel_reg != REG_AW'(REG_ZERO));
            write_reg  <= sel_reg;
            write_data <= sel_data;
        end else begin
            write_en   <= 1'b0;
        end
    end

    assign fwd_hit_1_out = write_en && (write_reg == reg_num_1_in);
    assign fwd_hit_2_out = write_en && (write_reg == reg_num_2_in);

    assert property (@(posedge clk) $onehot0(req_ready_out));

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_contract
        assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid_in[g] && !req_ready_out[g]) |=>
                (req_valid_in[g]
                 && $stable(req_reg_in[g*REG_AW +: REG_AW])
                 && $stable(req_data_in[g*XLEN +: XLEN])));
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// constrained-random traffic against a behavioural model of the write port.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int N  = 3;
    localparam int XW = 64;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid_in;
    logic [N*AW-1:0] req_reg_in;
    logic [N*XW-1:0] req_data_in;
    logic [N-1:0]    req_ready_out;
    logic            stall_in;
    logic            write_en;
    logic [AW-1:0]   write_reg;
    logic [XW-1:0]   write_data;
    logic [AW-1:0]   reg_num_1_in;
    logic [AW-1:0]   reg_num_2_in;
    logic            fwd_hit_1_out;
    logic            fwd_hit_2_out;

    regfile_wb_arbiter #(
        .NUM_REQ (N),
        .XLEN    (XW),
        .REG_AW  (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_in  (req_valid_in),
        .req_reg_in    (req_reg_in),
        .req_data_in   (req_data_in),
        .req_ready_out (req_ready_out),
        .stall_in      (stall_in),
        .write_en      (write_en),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .reg_num_1_in  (reg_num_1_in),
        .reg_num_2_in  (reg_num_2_in),
        .fwd_hit_1_out (fwd_hit_1_out),
        .fwd_hit_2_out (fwd_hit_2_out)
    );

    always #5 clk = ~clk;

    // Requester-side state
    wb_req_t     pend [N];
    logic [N-1:0] vld;
    logic [N-1:0] acc;

    // Behavioural model of the write port
    int            m_ptr;
    logic          m_en;
    logic [AW-1:0] m_reg;
    logic [XW-1:0] m_data;
    int            wait_cnt [N];
    logic [N-1:0]  dut_rdy;

    int n_chk;
    int n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_reg_in[i*AW +: AW]  = pend[i].rd;
            req_data_in[i*XW +: XW] = pend[i].data;
        end
        req_valid_in = vld;
    endtask

    // Winner is the valid requester closest to ptr going upward around the ring.
    function automatic logic [N-1:0] model_grant();
        int best;
        int bestd;
        logic [N-1:0] g;
        g     = '0;
        best  = -1;
        bestd = N;
        if (rst_n !== 1'b1 || stall_in) return g;
        for (int i = 0; i < N; i++) begin
            if (vld[i]) begin
                int d;
                d = (i - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        if (best >= 0) g[best] = 1'b1;
        return g;
    endfunction

    task automatic settle();
        #2;
        dut_rdy = req_ready_out;
        chk("ready", req_ready_out, model_grant());
        chk("write_en", write_en, m_en);
        chk("write_reg", write_reg, m_reg);
        chk("write_data", write_data, m_data);
        chk("fwd_hit_1", fwd_hit_1_out, m_en && (m_reg == reg_num_1_in));
        chk("fwd_hit_2", fwd_hit_2_out, m_en && (m_reg == reg_num_2_in));
    endtask

    task automatic advance();
        logic [N-1:0] g;
        @(posedge clk);
        g   = model_grant();
        acc = g;
        for (int i = 0; i < N; i++) begin
            if (rst_n !== 1'b1 || !vld[i]) begin
                wait_cnt[i] = 0;
            end else if (dut_rdy[i]) begin
                chk("fairness", 64'(wait_cnt[i] < N), 64'(1));
                wait_cnt[i] = 0;
            end else if (!stall_in) begin
                wait_cnt[i]++;
            end
        end
        if (rst_n !== 1'b1) begin
            m_ptr  = 0;
            m_en   = 1'b0;
            m_reg  = '0;
            m_data = '0;
        end else if (g != '0) begin
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    m_ptr  = (i + 1) % N;
                    m_reg  = pend[i].rd;
                    m_data = pend[i].data;
                    m_en   = (pend[i].rd != '0);
                end
            end
        end else begin
            m_en = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        stall_in = 1'b0;
        reg_num_1_in = '0;
        reg_num_2_in = '0;
        vld = '0;
        acc = '0;
        dut_rdy = '0;
        m_ptr = 0;
        m_en = 1'b0;
        m_reg = '0;
        m_data = '0;
        for (int i = 0; i < N; i++) begin
            pend[i]     = '{rd: AW'(10 + i), data: 64'hA000 + 64'(i)};
            wait_cnt[i] = 0;
        end
        drive();
        @(posedge clk);
        @(negedge clk);

        // Reset held with every requester valid
        vld = 3'b111;
        drive();
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("rst_ready", req_ready_out, 64'(0));
            chk("rst_write_en", write_en, 64'(0));
            advance();
        end

        // Release: round-robin 0,1,2,0,1,2 with back-to-back write pulses
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("rr_grant", req_ready_out, 64'(1 << (k % 3)));
            if (k > 0) chk("rr_pulse", write_en, 64'(1));
            advance();
        end
        vld[2] = 1'b0;
        drive();
        settle();
        chk("rr_grant", req_ready_out, 64'(3'b001));
        chk("rr_pulse", write_en, 64'(1));
        chk("rr_reg", write_reg, 64'(12));
        advance();
        vld[0] = 1'b0;
        drive();
        settle();
        chk("rr_grant", req_ready_out, 64'(3'b010));
        advance();
        vld[1] = 1'b0;
        drive();
        settle();
        chk("rr_reg", write_reg, 64'(11));
        chk("idle_ready", req_ready_out, 64'(0));
        advance();

        // Single request with forwarding on port 1
        pend[1] = '{rd: AW'(5), data: 64'hDEAD_BEEF};
        vld = 3'b010;
        drive();
        settle();
        chk("single_ready", req_ready_out, 64'(3'b010));
        advance();
        vld = '0;
        reg_num_1_in = AW'(5);
        reg_num_2_in = AW'(6);
        drive();
        settle();
        chk("single_en", write_en, 64'(1));
        chk("single_reg", write_reg, 64'(5));
        chk("single_data", write_data, 64'hDEAD_BEEF);
        chk("single_fwd1", fwd_hit_1_out, 64'(1));
        chk("single_fwd2", fwd_hit_2_out, 64'(0));
        advance();

        // x0 write: granted, no write_en, no forward hit
        pend[2] = '{rd: AW'(0), data: 64'h1};
        vld = 3'b100;
        drive();
        settle();
        chk("x0_ready", req_ready_out, 64'(3'b100));
        advance();
        vld = '0;
        reg_num_1_in = '0;
        reg_num_2_in = '0;
        drive();
        settle();
        chk("x0_en", write_en, 64'(0));
        chk("x0_fwd1", fwd_hit_1_out, 64'(0));
        chk("x0_fwd2", fwd_hit_2_out, 64'(0));
        advance();

        // Pointer wrapped to 0 after the x0 grant: requester 1 beats 2
        pend[1] = '{rd: AW'(3), data: 64'h3333};
        pend[2] = '{rd: AW'(4), data: 64'h4444};
        vld = 3'b110;
        drive();
        settle();
        chk("wrap_ready", req_ready_out, 64'(3'b010));
        advance();
        vld = 3'b100;
        drive();
        settle();
        chk("wrap_ready", req_ready_out, 64'(3'b100));
        advance();

        // Stall for three cycles; in-flight write still completes
        stall_in = 1'b1;
        pend[0] = '{rd: AW'(7), data: 64'hCAFE_F00D};
        vld = 3'b001;
        drive();
        settle();
        chk("stall_ready", req_ready_out, 64'(0));
        chk("stall_inflight_en", write_en, 64'(1));
        chk("stall_inflight_reg", write_reg, 64'(4));
        advance();
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("stall_ready", req_ready_out, 64'(0));
            chk("stall_en", write_en, 64'(0));
            advance();
        end
        stall_in = 1'b0;
        settle();
        chk("unstall_ready", req_ready_out, 64'(3'b001));
        advance();
        vld = '0;
        drive();
        settle();
        chk("unstall_en", write_en, 64'(1));
        chk("unstall_reg", write_reg, 64'(7));
        chk("unstall_data", write_data, 64'hCAFE_F00D);
        advance();

        // Reset right after a handshake: pointer returns to 0
        pend[1] = '{rd: AW'(9), data: 64'h9999};
        vld = 3'b010;
        drive();
        settle();
        chk("mid_ready", req_ready_out, 64'(3'b010));
        advance();
        vld = '0;
        rst_n = 1'b0;
        drive();
        settle();
        chk("mid_rst_ready", req_ready_out, 64'(0));
        advance();
        rst_n = 1'b1;
        settle();
        chk("mid_rst_en", write_en, 64'(0));
        advance();
        vld = 3'b101;
        drive();
        settle();
        chk("mid_rst_ptr", req_ready_out, 64'(3'b001));
        advance();
        vld = 3'b100;
        drive();
        settle();
        chk("mid_rst_next", req_ready_out, 64'(3'b100));
        advance();
        vld = '0;
        drive();
        settle();
        advance();

        // Randomised traffic; a requester changes only when idle or just accepted
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] || acc[i]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        vld[i]       = 1'b1;
                        pend[i].rd   = ($urandom_range(0, 9) == 0) ? AW'(0)
                                                                   : AW'($urandom_range(1, NUM_REGS - 1));
                        pend[i].data = {$urandom, $urandom};
                    end else begin
                        vld[i] = 1'b0;
                    end
                end
            end
            stall_in     = ($urandom_range(0, 99) < 15);
            rst_n        = ($urandom_range(0, 199) != 0);
            reg_num_1_in = $urandom_range(0, 1) ? m_reg : AW'($urandom_range(0, NUM_REGS - 1));
            reg_num_2_in = $urandom_range(0, 1) ? m_reg : AW'($urandom_range(0, NUM_REGS - 1));
            drive();
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
